// File: rtl/pll_dyn_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module   : pll_dyn_ctrl_if
// Brief    : Request, status and PLLVR divider/lock bundle of pll_dyn_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
interface pll_dyn_ctrl_if #(
    parameter int IW = 2
);
    logic          key;
    logic          sel_req;
    logic [IW-1:0] sel_idx;
    logic          lock_i;
    logic [5:0]    fdiv;
    logic [5:0]    idiv;
    logic [5:0]    odiv;
    logic          pll_reset;
    logic [IW-1:0] cur_idx;
    logic          locked;
    logic          busy;
    logic          fault;

    modport master (
        output key, sel_req, sel_idx, lock_i,
        input  fdiv, idiv, odiv, pll_reset, cur_idx, locked, busy, fault
    );

    modport slave (
        input  key, sel_req, sel_idx, lock_i,
        output fdiv, idiv, odiv, pll_reset, cur_idx, locked, busy, fault
    );
endinterface
`default_nettype wire

// File: rtl/pll_dyn_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : pll_dyn_ctrl
// Brief    : Preset-table frequency switcher for the Gowin PLLVR dynamic
//            dividers: key/select request, reset pulse, lock wait with retry.
// Revision : 1.0 - initial release
//==============================================================================
module pll_dyn_ctrl #(
    parameter int          NUM_PRESETS     = 4,
    parameter logic [47:0] PRESET_FBDIV    = {8{6'd10}},
    parameter logic [47:0] PRESET_IDIV     = {8{6'd3}},
    parameter logic [47:0] PRESET_ODIV     = {8{6'b111100}},
    parameter int          DEBOUNCE_CYCLES = 270000,
    parameter int          RESET_CYCLES    = 16,
    parameter int          LOCK_STABLE     = 8,
    parameter int          LOCK_TIMEOUT    = 1048576
) (
    input  logic          clk,
    input  logic          rst,
    pll_dyn_ctrl_if.slave bus
);
    localparam int IW  = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RCW = $clog2(RESET_CYCLES + 1);
    localparam int LSW = $clog2(LOCK_STABLE + 1);
    localparam int LTW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [DBW-1:0] c_DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] c_RST_LAST = RCW'(RESET_CYCLES - 1);
    localparam logic [LSW-1:0] c_LS_LAST  = LSW'(LOCK_STABLE - 1);
    localparam logic [LTW-1:0] c_TO_LAST  = LTW'(LOCK_TIMEOUT - 1);
    localparam logic [IW:0]    c_NUM      = (IW + 1)'(NUM_PRESETS);
    localparam logic [IW-1:0]  c_LAST_IDX = IW'(NUM_PRESETS - 1);
    localparam logic [5:0]     c_FDIV0    = ~(PRESET_FBDIV[5:0] - 6'd1);
    localparam logic [5:0]     c_IDIV0    = ~(PRESET_IDIV[5:0] - 6'd1);
    localparam logic [5:0]     c_ODIV0    = PRESET_ODIV[5:0];

    localparam logic [1:0] c_ST_APPLY  = 2'd0;
    localparam logic [1:0] c_ST_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    logic           r_key_meta, r_key_sync, r_key_db, r_key_evt;
    logic           r_lock_meta, r_lock_sync;
    logic [DBW-1:0] r_db_cnt;
    logic [1:0]     r_state;
    logic [IW-1:0]  r_cur_idx;
    logic [5:0]     r_fdiv, r_idiv, r_odiv;
    logic           r_pll_reset, r_locked, r_fault;
    logic [RCW-1:0] r_rst_cnt;
    logic [LSW-1:0] r_stab_cnt;
    logic [LTW-1:0] r_to_cnt;

    logic [5:0]     w_fb_tab [0:7];
    logic [5:0]     w_id_tab [0:7];
    logic [5:0]     w_od_tab [0:7];
    logic           w_sel_ok, w_req;
    logic [IW-1:0]  w_next_idx, w_target;
    logic [2:0]     w_tab_idx;

    for (genvar gi = 0; gi < 8; gi++) begin : g_table
        assign w_fb_tab[gi] = PRESET_FBDIV[6*gi +: 6];
        assign w_id_tab[gi] = PRESET_IDIV[6*gi +: 6];
        assign w_od_tab[gi] = PRESET_ODIV[6*gi +: 6];
    end

    // A select request, valid or not, always shadows a coincident key event.
    assign w_sel_ok   = bus.sel_req && ({1'b0, bus.sel_idx} < c_NUM);
    assign w_next_idx = (r_cur_idx == c_LAST_IDX) ? '0 : r_cur_idx + 1'b1;
    assign w_req      = bus.sel_req ? w_sel_ok : r_key_evt;
    assign w_target   = bus.sel_req ? bus.sel_idx : w_next_idx;
    assign w_tab_idx  = 3'(w_target);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_meta  <= 1'b0;
            r_key_sync  <= 1'b0;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_key_db    <= 1'b0;
            r_key_evt   <= 1'b0;
            r_db_cnt    <= '0;
        end else begin
            r_key_meta  <= bus.key;
            r_key_sync  <= r_key_meta;
            r_lock_meta <= bus.lock_i;
            r_lock_sync <= r_lock_meta;
            r_key_evt   <= 1'b0;
            if (r_key_sync == r_key_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_db_cnt  <= '0;
                r_key_db  <= r_key_sync;
                r_key_evt <= r_key_sync;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_APPLY;
            r_cur_idx   <= '0;
            r_fdiv      <= c_FDIV0;
            r_idiv      <= c_IDIV0;
            r_odiv      <= c_ODIV0;
            r_pll_reset <= 1'b1;
            r_locked    <= 1'b0;
            r_fault     <= 1'b0;
            r_rst_cnt   <= '0;
            r_stab_cnt  <= '0;
            r_to_cnt    <= '0;
        end else begin
            case (r_state)
                c_ST_APPLY: begin
                    if (r_rst_cnt == c_RST_LAST) begin
                        r_rst_cnt   <= '0;
                        r_stab_cnt  <= '0;
                        r_to_cnt    <= '0;
                        r_pll_reset <= 1'b0;
                        r_state     <= c_ST_WAIT;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                c_ST_WAIT: begin
                    if (r_lock_sync && (r_stab_cnt == c_LS_LAST)) begin
                        r_locked <= 1'b1;
                        r_fault  <= 1'b0;
                        r_state  <= c_ST_LOCKED;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        // Retry the same preset; dividers are left untouched.
                        r_fault     <= 1'b1;
                        r_pll_reset <= 1'b1;
                        r_rst_cnt   <= '0;
                        r_state     <= c_ST_APPLY;
                    end else begin
                        r_to_cnt   <= r_to_cnt + 1'b1;
                        r_stab_cnt <= r_lock_sync ? r_stab_cnt + 1'b1 : '0;
                    end
                end
                c_ST_LOCKED: begin
                    if (w_req) begin
                        r_cur_idx   <= w_target;
                        r_fdiv      <= ~(w_fb_tab[w_tab_idx] - 6'd1);
                        r_idiv      <= ~(w_id_tab[w_tab_idx] - 6'd1);
                        r_odiv      <= w_od_tab[w_tab_idx];
                        r_pll_reset <= 1'b1;
                        r_locked    <= 1'b0;
                        r_rst_cnt   <= '0;
                        r_state     <= c_ST_APPLY;
                    end else if (!r_lock_sync) begin
                        r_locked   <= 1'b0;
                        r_stab_cnt <= '0;
                        r_to_cnt   <= '0;
                        r_state    <= c_ST_WAIT;
                    end
                end
                default: begin
                    r_pll_reset <= 1'b1;
                    r_locked    <= 1'b0;
                    r_rst_cnt   <= '0;
                    r_state     <= c_ST_APPLY;
                end
            endcase
        end
    end

    assign bus.fdiv      = r_fdiv;
    assign bus.idiv      = r_idiv;
    assign bus.odiv      = r_odiv;
    assign bus.pll_reset = r_pll_reset;
    assign bus.cur_idx   = r_cur_idx;
    assign bus.locked    = r_locked;
    assign bus.busy      = ~r_locked;
    assign bus.fault     = r_fault;
endmodule
`default_nettype wire

// File: tb/tb_pll_dyn_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_pll_dyn_ctrl
// Brief    : Self-checking bench for pll_dyn_ctrl (vector table, corner
//            sequences, randomized switching against an index/preset model).
// Revision : 1.0 - initial release
//==============================================================================
module tb_pll_dyn_ctrl;
    localparam int c_NP = 4;
    localparam int c_DB = 100;
    localparam int c_RC = 16;
    localparam int c_LS = 8;
    localparam int c_LT = 64;
    localparam logic [47:0] c_FB = {6'd17, 6'd16, 6'd15, 6'd14, 6'd13, 6'd12, 6'd11, 6'd10};
    localparam logic [47:0] c_ID = {6'd10, 6'd9, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3};
    localparam logic [47:0] c_OD = {6'd6, 6'd1, 6'd32, 6'd16, 6'd4, 6'd2, 6'd8, 6'd60};

    localparam int K_SEL = 0, K_KEY = 1, K_BUSY = 2, K_BOUNCE = 3;

    typedef struct {
        int kind;
        int idx;
        int idx2;
        int exp_idx;
        int exp_pulses;
    } vec_t;

    // Real divider values and raw odiv codes of each preset.
    int m_fb [8] = '{10, 11, 12, 13, 14, 15, 16, 17};
    int m_id [8] = '{3, 4, 5, 6, 7, 8, 9, 10};
    int m_od [8] = '{60, 8, 2, 4, 16, 32, 1, 6};

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   pw_cur = 0;
    int   pw_last = 0;
    int   m_idx, p0, n, lat, seen;
    vec_t tv [11];

    always #5 clk = ~clk;

    pll_dyn_ctrl_if #(.IW(2)) bus  ();
    pll_dyn_ctrl_if #(.IW(2)) bus3 ();

    pll_dyn_ctrl #(
        .NUM_PRESETS(c_NP), .PRESET_FBDIV(c_FB), .PRESET_IDIV(c_ID), .PRESET_ODIV(c_OD),
        .DEBOUNCE_CYCLES(c_DB), .RESET_CYCLES(c_RC), .LOCK_STABLE(c_LS), .LOCK_TIMEOUT(c_LT)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    pll_dyn_ctrl #(
        .NUM_PRESETS(3), .PRESET_FBDIV(c_FB), .PRESET_IDIV(c_ID), .PRESET_ODIV(c_OD),
        .DEBOUNCE_CYCLES(c_DB), .RESET_CYCLES(c_RC), .LOCK_STABLE(c_LS), .LOCK_TIMEOUT(c_LT)
    ) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // pll_reset pulse counter and width of the most recent pulse.
    always @(negedge clk) begin
        if (bus.pll_reset === 1'b1) begin
            pw_cur = pw_cur + 1;
        end else if (pw_cur != 0) begin
            pulses  = pulses + 1;
            pw_last = pw_cur;
            pw_cur  = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic chk_preset(input string nm, input int idx);
        chk({nm, "_cur_idx"}, bus.cur_idx, idx);
        chk({nm, "_fdiv"}, bus.fdiv, 64 - m_fb[idx]);
        chk({nm, "_idiv"}, bus.idiv, 64 - m_id[idx]);
        chk({nm, "_odiv"}, bus.odiv, m_od[idx]);
    endtask

    task automatic settle(input string nm);
        int k = 0;
        while (!(bus.locked === 1'b1 && bus.pll_reset === 1'b0) && k < 600) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 600) begin
            errors++;
            $display("FAIL %s_settle: locked=%b expected 1 within 600 cycles", nm, bus.locked);
        end
    endtask

    task automatic sel(input int idx);
        bus.sel_idx = 2'(idx);
        bus.sel_req = 1'b1;
        tick();
        bus.sel_req = 1'b0;
    endtask

    task automatic press_key();
        bus.key = 1'b1;
        repeat (200) tick();
        bus.key = 1'b0;
        repeat (150) tick();
    endtask

    task automatic wait_reset_low();
        int k = 0;
        while (bus.pll_reset === 1'b1 && k < 60) begin
            tick();
            k++;
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{K_KEY,    0, 0, 1, 1};
        tv[1]  = '{K_KEY,    0, 0, 2, 1};
        tv[2]  = '{K_KEY,    0, 0, 3, 1};
        tv[3]  = '{K_KEY,    0, 0, 0, 1};
        tv[4]  = '{K_SEL,    2, 0, 2, 1};
        tv[5]  = '{K_BUSY,   1, 3, 1, 1};
        tv[6]  = '{K_BOUNCE, 0, 0, 1, 0};
        tv[7]  = '{K_SEL,    0, 0, 0, 1};
        tv[8]  = '{K_SEL,    0, 0, 0, 1};
        tv[9]  = '{K_KEY,    0, 0, 1, 1};
        tv[10] = '{K_SEL,    3, 0, 3, 1};

        rst = 1'b0;
        bus.key = 1'b0;  bus.sel_req = 1'b0;  bus.sel_idx = '0;  bus.lock_i = 1'b1;
        bus3.key = 1'b0; bus3.sel_req = 1'b0; bus3.sel_idx = '0; bus3.lock_i = 1'b1;
        repeat (3) tick();

        chk("rst_pll_reset", bus.pll_reset, 1);
        chk("rst_locked", bus.locked, 0);
        chk("rst_busy", bus.busy, 1);
        chk("rst_fault", bus.fault, 0);
        chk_preset("rst", 0);

        rst = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.pll_reset === 1'b1 && n < 100);
        chk("init_pulse_len", n, c_RC);
        n = 0;
        while (bus.locked !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk_range("init_lock_latency", n, c_LS, c_LS + 2);
        chk_preset("init", 0);
        chk("init_busy", bus.busy, 0);
        m_idx = 0;

        // Three-entry instance: out-of-range select is dropped, key wraps to 0.
        bus3.sel_idx = 2'd3;
        bus3.sel_req = 1'b1;
        tick();
        bus3.sel_req = 1'b0;
        seen = 0;
        repeat (20) begin
            if (bus3.pll_reset === 1'b1) seen++;
            tick();
        end
        chk("np3_oor_pulse", seen, 0);
        chk("np3_oor_idx", bus3.cur_idx, 0);
        bus3.sel_idx = 2'd2;
        bus3.sel_req = 1'b1;
        tick();
        bus3.sel_req = 1'b0;
        chk("np3_sel_idx", bus3.cur_idx, 2);
        repeat (40) tick();
        bus3.key = 1'b1;
        repeat (200) tick();
        bus3.key = 1'b0;
        repeat (150) tick();
        chk("np3_wrap_idx", bus3.cur_idx, 0);
        chk("np3_wrap_locked", bus3.locked, 1);

        for (int v = 0; v < 11; v++) begin
            p0 = pulses;
            case (tv[v].kind)
                K_SEL: begin
                    sel(tv[v].idx);
                    if (tv[v].exp_pulses != 0) begin
                        chk("vec_lat_idx", bus.cur_idx, tv[v].idx);
                        chk("vec_lat_pll_reset", bus.pll_reset, 1);
                        chk("vec_lat_busy", bus.busy, 1);
                    end
                end
                K_KEY: press_key();
                K_BUSY: begin
                    sel(tv[v].idx);
                    chk("vec_busy_flag", bus.busy, 1);
                    sel(tv[v].idx2);
                end
                default: begin
                    repeat (5) begin
                        bus.key = 1'b1;
                        repeat (30) tick();
                        bus.key = 1'b0;
                        repeat (20) tick();
                    end
                    repeat (150) tick();
                end
            endcase
            repeat (20) tick();
            settle("vec");
            chk("vec_pulses", pulses - p0, tv[v].exp_pulses);
            if (tv[v].exp_pulses != 0) chk("vec_pulse_width", pw_last, c_RC);
            chk_preset("vec", tv[v].exp_idx);
            chk("vec_fault", bus.fault, 0);
        end
        m_idx = 3;

        // Measure key-to-switch latency, then collide a select with the key event.
        p0 = pulses;
        bus.key = 1'b1;
        n = 0;
        while (bus.pll_reset !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        lat = n;
        chk_range("key_latency", lat, c_DB + 2, c_DB + 5);
        repeat (200 - lat) tick();
        bus.key = 1'b0;
        repeat (150) tick();
        settle("cal");
        m_idx = (m_idx + 1) % c_NP;
        chk_preset("cal", m_idx);
        sel(0);
        settle("pre_prio");
        p0 = pulses;
        bus.key = 1'b1;
        repeat (lat - 1) tick();
        bus.sel_idx = 2'd2;
        bus.sel_req = 1'b1;
        tick();
        bus.sel_req = 1'b0;
        chk("prio_immediate_idx", bus.cur_idx, 2);
        repeat (200 - lat) tick();
        bus.key = 1'b0;
        repeat (150) tick();
        settle("prio");
        chk("prio_pulses", pulses - p0, 1);
        chk_preset("prio", 2);

        // Lock drop while LOCKED: no new reset pulse, relock after stable window.
        p0 = pulses;
        bus.lock_i = 1'b0;
        n = 0;
        while (bus.locked === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk_range("drop_latency", n, 2, 4);
        chk("drop_pll_reset", bus.pll_reset, 0);
        chk("drop_busy", bus.busy, 1);
        bus.lock_i = 1'b1;
        n = 0;
        while (bus.locked !== 1'b1 && n < 50) begin
            if (bus.pll_reset === 1'b1) seen++;
            tick();
            n++;
        end
        chk_range("relock_latency", n, c_LS + 2, c_LS + 4);
        chk("relock_pulses", pulses - p0, 0);
        chk_preset("relock", 2);

        // Lock never arrives: timeout, fault and automatic retry on the same preset.
        p0 = pulses;
        bus.lock_i = 1'b0;
        n = 0;
        while (bus.locked === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        n = 0;
        while (bus.pll_reset !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_len", n, c_LT);
        chk("timeout_fault", bus.fault, 1);
        chk("timeout_idx", bus.cur_idx, 2);
        wait_reset_low();
        bus.lock_i = 1'b1;
        settle("retry");
        chk("retry_fault", bus.fault, 0);
        chk("retry_pulses", pulses - p0, 1);
        chk("retry_pulse_width", pw_last, c_RC);
        chk_preset("retry", 2);

        // Short lock glitch inside WAIT_LOCK restarts the stable count only.
        p0 = pulses;
        sel(1);
        bus.lock_i = 1'b0;
        wait_reset_low();
        bus.lock_i = 1'b1;
        repeat (5) tick();
        bus.lock_i = 1'b0;
        repeat (2) tick();
        bus.lock_i = 1'b1;
        n = 0;
        while (bus.locked !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk_range("glitch_lock_latency", n, c_LS + 2, c_LS + 4);
        chk("glitch_fault", bus.fault, 0);
        chk("glitch_pulses", pulses - p0, 1);
        chk_preset("glitch", 1);
        m_idx = 1;

        for (int it = 0; it < 24; it++) begin
            int r, idx, d;
            r = $urandom_range(0, 9);
            p0 = pulses;
            if (r < 2) begin
                press_key();
                m_idx = (m_idx + 1) % c_NP;
            end else begin
                idx = $urandom_range(0, c_NP - 1);
                sel(idx);
                m_idx = idx;
                if (r < 5) sel($urandom_range(0, c_NP - 1));
                bus.lock_i = 1'b0;
                wait_reset_low();
                d = $urandom_range(0, 40);
                repeat (d) tick();
                bus.lock_i = 1'b1;
            end
            repeat (5) tick();
            settle("rnd");
            chk("rnd_pulses", pulses - p0, 1);
            chk_preset("rnd", m_idx);
            chk("rnd_fault", bus.fault, 0);
        end

        // Asynchronous reset in the middle of a switch to preset 3.
        sel(3);
        bus.lock_i = 1'b0;
        wait_reset_low();
        repeat (5) tick();
        chk("mid_pre_idx", bus.cur_idx, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_pll_reset", bus.pll_reset, 1);
        chk("mid_rst_locked", bus.locked, 0);
        chk("mid_rst_busy", bus.busy, 1);
        chk_preset("mid_rst", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
